// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Purpose  : Multi-port register file with write-through bypass and a
//            per-register busy scoreboard for pipeline hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
   parameter int DW       = 32,
   parameter int DEPTH    = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NRD*$clog2(DEPTH)-1:0]     i_rd_addr,
   output logic [NRD*DW-1:0]                o_rd_dat,
   output logic [NRD-1:0]                   o_rd_busy,
   input  logic [NWR-1:0]                   i_wr_en,
   input  logic [NWR*$clog2(DEPTH)-1:0]     i_wr_addr,
   input  logic [NWR*DW-1:0]                i_wr_dat,
   input  logic                             i_alloc_en,
   input  logic [$clog2(DEPTH)-1:0]         i_alloc_addr,
   input  logic [$clog2(DEPTH)-1:0]         top_regfile_addr,
   output logic [DW-1:0]                    top_regfile_data,
   output logic [$clog2(DEPTH):0]           o_busy_cnt
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0]    r_regs [DEPTH];
   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_nxt;
   logic [AW:0]      r_busy_cnt;
   logic [AW:0]      w_busy_cnt_nxt;
   logic [NWR-1:0]   w_wr_act;

   // Writes are masked while reset is held so bypassed reads also show zero.
   assign w_wr_act = i_wr_en & {NWR{rst_n}};

   always_comb begin
      w_busy_nxt = r_busy;
      for (int k = 0; k < NWR; k++) begin
         if (w_wr_act[k]) begin
            w_busy_nxt[i_wr_addr[k*AW +: AW]] = 1'b0;
         end
      end
      if (i_alloc_en) begin
         w_busy_nxt[i_alloc_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         w_busy_nxt[0] = 1'b0;
      end
   end

   always_comb begin
      w_busy_cnt_nxt = '0;
      for (int r = 0; r < DEPTH; r++) begin
         w_busy_cnt_nxt = w_busy_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[r]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= w_busy_cnt_nxt;
      end
   end

   // Ascending loop: a higher-indexed port to the same address overrides.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DEPTH; r++) begin
            r_regs[r] <= '0;
         end
      end else begin
         for (int k = 0; k < NWR; k++) begin
            if (i_wr_en[k] && !(ZERO_REG != 0 && i_wr_addr[k*AW +: AW] == '0)) begin
               r_regs[i_wr_addr[k*AW +: AW]] <= i_wr_dat[k*DW +: DW];
            end
         end
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic [DW-1:0] w_dat;
      logic          w_hit;

      assign w_addr = i_rd_addr[p*AW +: AW];

      always_comb begin
         w_hit = 1'b0;
         w_dat = r_regs[w_addr];
         for (int k = 0; k < NWR; k++) begin
            if (w_wr_act[k] && i_wr_addr[k*AW +: AW] == w_addr) begin
               w_hit = 1'b1;
               w_dat = i_wr_dat[k*DW +: DW];
            end
         end
         if (ZERO_REG != 0 && w_addr == '0) begin
            w_dat = '0;
         end
      end

      assign o_rd_dat[p*DW +: DW] = w_dat;
      assign o_rd_busy[p]         = r_busy[w_addr] & ~w_hit;
   end

   assign top_regfile_data = (ZERO_REG != 0 && top_regfile_addr == '0) ? '0
                                                                       : r_regs[top_regfile_addr];
   assign o_busy_cnt       = r_busy_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Purpose  : Directed and randomized self-checking bench for reg_file_mp.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

   localparam int DW    = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;
   localparam int NWR   = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [AW-1:0]     ra [NRD];
   logic [NWR-1:0]    we;
   logic [AW-1:0]     wa [NWR];
   logic [DW-1:0]     wd [NWR];
   logic              alloc_en;
   logic [AW-1:0]     alloc_addr;
   logic [AW-1:0]     dbg_addr;
   logic [NRD*DW-1:0] rd_dat;
   logic [NRD-1:0]    rd_busy;
   logic [DW-1:0]     dbg_dat;
   logic [AW:0]       busy_cnt;

   int compared   = 0;
   int mismatched = 0;

   logic [DW-1:0] m_reg  [DEPTH];
   bit            m_busy [DEPTH];

   always #5 clk = ~clk;

   reg_file_mp #(.DW(DW), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_rd_addr        ({ra[1], ra[0]}),
      .o_rd_dat         (rd_dat),
      .o_rd_busy        (rd_busy),
      .i_wr_en          (we),
      .i_wr_addr        ({wa[1], wa[0]}),
      .i_wr_dat         ({wd[1], wd[0]}),
      .i_alloc_en       (alloc_en),
      .i_alloc_addr     (alloc_addr),
      .top_regfile_addr (dbg_addr),
      .top_regfile_data (dbg_dat),
      .o_busy_cnt       (busy_cnt)
   );

   function automatic void model_reset();
      for (int r = 0; r < DEPTH; r++) begin
         m_reg[r]  = '0;
         m_busy[r] = 1'b0;
      end
   endfunction

   function automatic bit written(logic [AW-1:0] a);
      for (int k = 0; k < NWR; k++) if (we[k] && wa[k] == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [DW-1:0] exp_rd(logic [AW-1:0] a);
      logic [DW-1:0] v;
      if (!rst_n || a == 0) return '0;
      v = m_reg[a];
      for (int k = 0; k < NWR; k++) if (we[k] && wa[k] == a) v = wd[k];
      return v;
   endfunction

   function automatic bit exp_busy(logic [AW-1:0] a);
      if (!rst_n || a == 0) return 1'b0;
      return m_busy[a] && !written(a);
   endfunction

   function automatic int exp_cnt();
      int n = 0;
      for (int r = 0; r < DEPTH; r++) n += int'(m_busy[r]);
      return n;
   endfunction

   // Clock-edge effect of the current inputs on the reference state.
   function automatic void commit();
      bit nb [DEPTH];
      for (int r = 0; r < DEPTH; r++) begin
         if (alloc_en && alloc_addr == r && r != 0) nb[r] = 1'b1;
         else if (written(AW'(r)))                  nb[r] = 1'b0;
         else                                       nb[r] = m_busy[r];
      end
      for (int k = 0; k < NWR; k++) if (we[k] && wa[k] != 0) m_reg[wa[k]] = wd[k];
      for (int r = 0; r < DEPTH; r++) m_busy[r] = nb[r];
   endfunction

   task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_comb();
      for (int p = 0; p < NRD; p++) begin
         chk($sformatf("rd_dat%0d@%0d", p, ra[p]), rd_dat[p*DW +: DW], exp_rd(ra[p]));
         chk($sformatf("rd_busy%0d@%0d", p, ra[p]), {31'b0, rd_busy[p]}, {31'b0, exp_busy(ra[p])});
      end
   endtask

   task automatic check_seq();
      chk("busy_cnt", {26'b0, busy_cnt}, DW'(exp_cnt()));
      chk($sformatf("debug@%0d", dbg_addr), dbg_dat, (dbg_addr == 0) ? '0 : m_reg[dbg_addr]);
   endtask

   task automatic tick();
      #1 check_comb();
      @(posedge clk);
      commit();
      #1 check_seq();
   endtask

   task automatic idle();
      we       = '0;
      alloc_en = 1'b0;
   endtask

   function automatic logic [AW-1:0] raddr();
      if ($urandom_range(0, 2) == 0) return AW'($urandom_range(0, DEPTH-1));
      return AW'($urandom_range(0, 7));
   endfunction

   initial begin
      // Reset asserted with two writes pending
      rst_n = 1'b0; we = 2'b11; wa[0] = 5'd1; wa[1] = 5'd2;
      wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222;
      ra[0] = 5'd1; ra[1] = 5'd2; alloc_en = 1'b0; alloc_addr = '0; dbg_addr = 5'd1;
      model_reset();
      #3;
      chk("t1_rd0", rd_dat[31:0], 32'h0);
      chk("t1_rd1", rd_dat[63:32], 32'h0);
      chk("t1_cnt", {26'b0, busy_cnt}, 32'h0);
      check_comb();
      @(posedge clk); @(posedge clk);
      #1 check_comb(); check_seq();
      #3 idle(); rst_n = 1'b1;
      @(posedge clk);
      #1 check_comb(); check_seq();

      // Single write with bypass, then stored value and debug view
      we = 2'b01; wa[0] = 5'd5; wd[0] = 32'h1234_5678; ra[0] = 5'd5; ra[1] = 5'd5; dbg_addr = 5'd5;
      #1 chk("t2_bypass", rd_dat[31:0], 32'h1234_5678);
      tick();
      idle();
      #1 chk("t2_stored", rd_dat[31:0], 32'h1234_5678);
      chk("t2_debug", dbg_dat, 32'h1234_5678);
      tick();

      // Both ports to r7, then write to r0
      we = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 32'hAAAA_AAAA; wd[1] = 32'h5555_5555;
      ra[0] = 5'd7; ra[1] = 5'd0; dbg_addr = 5'd7;
      #1 chk("t3_bypass", rd_dat[31:0], 32'h5555_5555);
      tick();
      chk("t3_stored", dbg_dat, 32'h5555_5555);
      we = 2'b01; wa[0] = 5'd0; wd[0] = 32'hFFFF_FFFF; ra[0] = 5'd0; dbg_addr = 5'd0;
      #1 chk("t3_r0_rd", rd_dat[31:0], 32'h0);
      tick();
      chk("t3_r0_dbg", dbg_dat, 32'h0);

      // Alloc then retire r9
      idle(); alloc_en = 1'b1; alloc_addr = 5'd9; ra[0] = 5'd9; dbg_addr = 5'd9;
      tick();
      chk("t4_cnt1", {26'b0, busy_cnt}, 32'd1);
      idle();
      #1 chk("t4_busy", {31'b0, rd_busy[0]}, 32'd1);
      we = 2'b01; wa[0] = 5'd9; wd[0] = 32'hCAFE_BABE;
      #1 chk("t4_wr_busy", {31'b0, rd_busy[0]}, 32'd0);
      chk("t4_wr_dat", rd_dat[31:0], 32'hCAFE_BABE);
      tick();
      chk("t4_cnt0", {26'b0, busy_cnt}, 32'd0);

      // Alloc beats same-cycle write; alloc of r0 ignored
      we = 2'b01; wa[0] = 5'd9; wd[0] = 32'hDEAD_BEEF; alloc_en = 1'b1; alloc_addr = 5'd9;
      tick();
      idle();
      #1 chk("t5_busy", {31'b0, rd_busy[0]}, 32'd1);
      chk("t5_dbg", dbg_dat, 32'hDEAD_BEEF);
      alloc_en = 1'b1; alloc_addr = 5'd0;
      tick();
      chk("t5_cnt", {26'b0, busy_cnt}, 32'd1);

      // Allocations followed by mid-cycle reset
      idle(); alloc_en = 1'b1;
      alloc_addr = 5'd3;  tick();
      alloc_addr = 5'd4;  tick();
      alloc_addr = 5'd31; tick();
      chk("t6_cnt4", {26'b0, busy_cnt}, 32'd4);
      idle(); ra[0] = 5'd3; ra[1] = 5'd9;
      #1 check_comb();
      rst_n = 1'b0;
      #1 model_reset();
      chk("t6_rst_cnt", {26'b0, busy_cnt}, 32'd0);
      chk("t6_rst_rd", rd_dat[63:32], 32'h0);
      check_comb();
      #1 rst_n = 1'b1;
      tick();

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < NWR; k++) begin
            we[k] = ($urandom_range(0, 1) == 1);
            wa[k] = raddr();
            wd[k] = $urandom;
         end
         for (int p = 0; p < NRD; p++) ra[p] = raddr();
         alloc_en   = ($urandom_range(0, 2) != 0);
         alloc_addr = raddr();
         dbg_addr   = raddr();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
